// File: rtl/cmp_share_arbiter_pkg.sv
// Shared definitions for the compare-sharing arbiter: op codes and response FSM states.
package cmp_share_arbiter_pkg;

   localparam logic [2:0] CMP_ZERO = 3'b000;
   localparam logic [2:0] CMP_ONE  = 3'b001;
   localparam logic [2:0] CMP_EQ   = 3'b010;
   localparam logic [2:0] CMP_NE   = 3'b011;
   localparam logic [2:0] CMP_GE   = 3'b100;
   localparam logic [2:0] CMP_LE   = 3'b101;
   localparam logic [2:0] CMP_LT   = 3'b110;
   localparam logic [2:0] CMP_GT   = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/cmp_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or above i_ptr (with wrap) wins when enabled.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   // Priority search starting at the pointer; o_any latches the first hit.
   always_comb begin
      int j;
      j       = 0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j     = (int'(i_ptr) + k) % NREQ;
         o_idx = (!o_any && i_req[j]) ? IDW'(j) : o_idx;
         o_any = o_any | i_req[j];
      end
      o_grant = (i_en && o_any) ? (NREQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/cmp_share_arbiter.sv
// One shared unsigned comparator time-multiplexed among NREQ requesters through a
// round-robin arbiter; the result is registered and returned with the requester ID.
module cmp_share_arbiter
   import cmp_share_arbiter_pkg::*;
#(
   parameter int N    = 8,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_sel,
   input  logic [N*NREQ-1:0] req_a,
   input  logic [N*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_out,
   output logic [CNTW-1:0]   done_cnt
);

   state_t          r_state;
   logic [IDW-1:0]  r_rsp_id;
   logic            r_rsp_out;
   logic [CNTW-1:0] r_done_cnt;
   logic [IDW-1:0]  r_rr_ptr;

   logic            w_free;
   logic            w_any;
   logic            w_accept;
   logic [IDW-1:0]  w_idx;
   logic [2:0]      w_sel;
   logic [N-1:0]    w_a;
   logic [N-1:0]    w_b;
   logic [IDW-1:0]  w_ptr_next;

   function automatic logic cmp_eval(input logic [2:0] sel, input logic [N-1:0] a,
                                     input logic [N-1:0] b);
      case (sel)
         CMP_ZERO: cmp_eval = 1'b0;
         CMP_ONE:  cmp_eval = 1'b1;
         CMP_EQ:   cmp_eval = (a == b);
         CMP_NE:   cmp_eval = (a != b);
         CMP_GE:   cmp_eval = (a >= b);
         CMP_LE:   cmp_eval = (a <= b);
         CMP_LT:   cmp_eval = (a < b);
         CMP_GT:   cmp_eval = (a > b);
         default:  cmp_eval = 1'b0;
      endcase
   endfunction

   // Grants are suppressed while reset is held so nothing is offered against a cleared slot.
   assign w_free   = (r_state == ST_IDLE) | rsp_ready;
   assign w_accept = w_any & w_free & ~rst;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_free & ~rst),
      .o_grant (req_ready),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_sel      = req_sel[int'(w_idx)*3 +: 3];
   assign w_a        = req_a[int'(w_idx)*N +: N];
   assign w_b        = req_b[int'(w_idx)*N +: N];
   assign w_ptr_next = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);

   // Response FSM: IDLE holds no result, HOLD presents one until consumed or replaced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rsp_id   <= '0;
         r_rsp_out  <= 1'b0;
         r_done_cnt <= '0;
         r_rr_ptr   <= '0;
      end else begin
         if ((r_state == ST_HOLD) && rsp_ready) begin
            r_done_cnt <= r_done_cnt + CNTW'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (rsp_ready && !w_accept) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         if (w_accept) begin
            r_rsp_id  <= w_idx;
            r_rsp_out <= cmp_eval(w_sel, w_a, w_b);
            r_rr_ptr  <= w_ptr_next;
         end
      end
   end

   assign rsp_valid = (r_state == ST_HOLD);
   assign rsp_id    = r_rsp_id;
   assign rsp_out   = r_rsp_out;
   assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed self-checking bench for cmp_share_arbiter (N=8, NREQ=4, CNTW=16).
module tb_cmp_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = 4'b0000;
   logic [3:0]  req_ready;
   logic [11:0] req_sel = 12'h000;
   logic [31:0] req_a = 32'h0;
   logic [31:0] req_b = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic        rsp_out;
   logic [15:0] done_cnt;

   int errors = 0;
   int checks = 0;

   cmp_share_arbiter #(.N(8), .NREQ(4), .IDW(2), .CNTW(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_out(rsp_out), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   task automatic set_op(input int i, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      req_sel[3*i +: 3] = s;
      req_a[8*i +: 8]   = a;
      req_b[8*i +: 8]   = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #2;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_id !== 2'd0 || rsp_out !== 1'b0) begin errors++; $display("FAIL reset_rsp got id=%0d out=%b exp id=0 out=0", rsp_id, rsp_out); end
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", done_cnt); end
      req_valid = 4'b0000;
      step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_op(0, 3'b010, 8'd5, 8'd5);
      req_valid = 4'b0001; rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0000;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_out !== 1'b1) begin errors++; $display("FAIL t1_rsp got v=%b id=%0d out=%b exp v=1 id=0 out=1", rsp_valid, rsp_id, rsp_out); end
      step();
      checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL t1_cnt got=%0d exp=1", done_cnt); end
      checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_out !== 1'b1) begin errors++; $display("FAIL t1_drain got v=%b id=%0d out=%b exp v=0 id=0 out=1", rsp_valid, rsp_id, rsp_out); end
   endtask

   task automatic test_round_robin();
      int       order[6] = '{0, 1, 2, 3, 0, 1};
      logic     exp_out[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) set_op(i, 3'b110, 8'(i), 8'd2);
      // Grant req3 alone first so the pointer returns to 0.
      req_valid = 4'b1000; rsp_ready = 1'b1;
      step();
      checks++; if (rsp_id !== 2'd3 || rsp_out !== 1'b0) begin errors++; $display("FAIL t2_pre got id=%0d out=%b exp id=3 out=0", rsp_id, rsp_out); end
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #1;
         exp_rdy = 4'b0001 << order[k];
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL t2_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
         step();
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k]) || rsp_out !== exp_out[order[k]]) begin
            errors++; $display("FAIL t2_rsp k=%0d got v=%b id=%0d out=%b exp v=1 id=%0d out=%b", k, rsp_valid, rsp_id, rsp_out, order[k], exp_out[order[k]]);
         end
      end
      req_valid = 4'b0000;
      step();
      checks++; if (done_cnt !== 16'd8 || rsp_valid !== 1'b0) begin errors++; $display("FAIL t2_cnt got cnt=%0d v=%b exp cnt=8 v=0", done_cnt, rsp_valid); end
   endtask

   task automatic test_backpressure();
      set_op(2, 3'b111, 8'd9, 8'd3);
      set_op(3, 3'b000, 8'd1, 8'd1);
      set_op(0, 3'b001, 8'd0, 8'd0);
      req_valid = 4'b0100; rsp_ready = 1'b0;
      step();
      req_valid = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t3_ready k=%0d got=%b exp=0000", k, req_ready); end
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== 1'b1) begin errors++; $display("FAIL t3_hold k=%0d got v=%b id=%0d out=%b exp v=1 id=2 out=1", k, rsp_valid, rsp_id, rsp_out); end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t3_regrant got=%b exp=1000", req_ready); end
      step();
      req_valid = 4'b0000;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_out !== 1'b0 || done_cnt !== 16'd9) begin
         errors++; $display("FAIL t3_swap got v=%b id=%0d out=%b cnt=%0d exp v=1 id=3 out=0 cnt=9", rsp_valid, rsp_id, rsp_out, done_cnt);
      end
      step();
      checks++; if (done_cnt !== 16'd10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_cnt got cnt=%0d v=%b exp cnt=10 v=0", done_cnt, rsp_valid); end
   endtask

   task automatic test_opcodes();
      logic exp_tab[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      req_valid = 4'b0100; rsp_ready = 1'b1;
      for (int s = 0; s < 8; s++) begin
         set_op(2, 3'(s), 8'hFF, 8'h00);
         step();
         checks++; if (rsp_id !== 2'd2 || rsp_out !== exp_tab[s]) begin errors++; $display("FAIL t4_sel%0d got id=%0d out=%b exp id=2 out=%b", s, rsp_id, rsp_out, exp_tab[s]); end
      end
      set_op(2, 3'b110, 8'h00, 8'hFF);
      step();
      req_valid = 4'b0000;
      checks++; if (rsp_out !== 1'b1) begin errors++; $display("FAIL t4_lt got=%b exp=1", rsp_out); end
      step();
      checks++; if (done_cnt !== 16'd19) begin errors++; $display("FAIL t4_cnt got=%0d exp=19", done_cnt); end
   endtask

   task automatic test_reset_mid_op();
      set_op(1, 3'b001, 8'd0, 8'd0);
      set_op(3, 3'b000, 8'd0, 8'd0);
      req_valid = 4'b0010; rsp_ready = 1'b0;
      step();
      req_valid = 4'b1010;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || done_cnt !== 16'd0) begin
         errors++; $display("FAIL t5_async got v=%b rdy=%b cnt=%0d exp v=0 rdy=0000 cnt=0", rsp_valid, req_ready, done_cnt);
      end
      step();
      rst = 1'b0; rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL t5_first got=%b exp=0010", req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_out !== 1'b1 || done_cnt !== 16'd0) begin
         errors++; $display("FAIL t5_rsp got v=%b id=%0d out=%b cnt=%0d exp v=1 id=1 out=1 cnt=0", rsp_valid, rsp_id, rsp_out, done_cnt);
      end
      step();
      req_valid = 4'b0000;
      checks++; if (rsp_id !== 2'd3 || rsp_out !== 1'b0 || done_cnt !== 16'd1) begin errors++; $display("FAIL t5_next got id=%0d out=%b cnt=%0d exp id=3 out=0 cnt=1", rsp_id, rsp_out, done_cnt); end
      step();
   endtask

   task automatic test_wrap();
      // done_cnt is 2 here; 65534 back-to-back req3 ops leave 65533 consumed and one pending.
      set_op(3, 3'b001, 8'd0, 8'd0);
      req_valid = 4'b1000; rsp_ready = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      checks++; if (done_cnt !== 16'hFFFF || rsp_valid !== 1'b1) begin errors++; $display("FAIL t6_preload got cnt=%h v=%b exp cnt=ffff v=1", done_cnt, rsp_valid); end
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t6_req3 got=%b exp=1000", req_ready); end
      step();
      checks++; if (done_cnt !== 16'h0000 || rsp_id !== 2'd3) begin errors++; $display("FAIL t6_wrap got cnt=%h id=%0d exp cnt=0000 id=3", done_cnt, rsp_id); end
      set_op(1, 3'b000, 8'd0, 8'd0);
      set_op(0, 3'b001, 8'd0, 8'd0);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t6_search_wrap got=%b exp=0001", req_ready); end
      step();
      req_valid = 4'b0000;
      checks++; if (rsp_id !== 2'd0 || rsp_out !== 1'b1 || done_cnt !== 16'd2) begin errors++; $display("FAIL t6_rsp got id=%0d out=%b cnt=%0d exp id=0 out=1 cnt=2", rsp_id, rsp_out, done_cnt); end
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_opcodes();
      test_reset_mid_op();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
